// File: rtl/keypad_pkg.sv
// Shared key codes, TX FSM states and the key-to-ASCII mapping for the keypad UART encoder.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE   = 4'd11;
  localparam logic [3:0] KEY_UNLOCK = 4'd13;
  localparam logic [3:0] KEY_A      = 4'd14;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} tx_state_t;

  typedef struct packed {
    logic       valid;
    logic       unlock;
    logic [7:0] ascii;
  } key_code_t;

  // Digits map to '0'..'9', KEY_A to 'A', KEY_UNLOCK to '7' plus an unlock event.
  function automatic key_code_t key_to_ascii(input logic [3:0] num);
    key_code_t k;
    k = '0;
    if (num <= 4'd9) begin
      k.valid = 1'b1;
      k.ascii = 8'h30 + {4'h0, num};
    end else if (num == KEY_A) begin
      k.valid = 1'b1;
      k.ascii = 8'h41;
    end else if (num == KEY_UNLOCK) begin
      k.valid  = 1'b1;
      k.unlock = 1'b1;
      k.ascii  = 8'h37;
    end else if (num == KEY_NONE) begin
      k = '0;
    end
    return k;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO only succeeds when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/keypad_uart_encoder.sv
// Keypad front end: synchronise the press, map it to ASCII, queue it and strobe it into the UART.
module keypad_uart_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned START_CYCLES  = 4,
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_CYCLES = 25000000,
  parameter int unsigned UNLOCK_CYCLES = 50000000
) (
  input  logic       FPGA_CLK1_50,
  input  logic       reset_n,
  input  logic [3:0] num,
  input  logic       PB_state,
  input  logic       TxD_busy,
  output logic [7:0] TxD_data,
  output logic       TxD_start,
  output logic       unlock_signal,
  output logic [7:0] LED,
  output logic       overflow
);

  localparam int unsigned SW = $clog2(START_CYCLES + 1);
  localparam int unsigned RW = $clog2(REPEAT_CYCLES);
  localparam int unsigned UW = $clog2(UNLOCK_CYCLES + 1);

  logic            pb_s1_q, pb_s2_q, pb_prev_q;
  logic            press, repeat_hit, push, pop, full, empty;
  logic [7:0]      push_data, head;
  key_code_t       key;
  logic [RW-1:0]   rep_cnt_q;
  logic            rep_active_q;
  logic [7:0]      rep_code_q;
  logic [UW-1:0]   unlock_cnt_q;
  logic [7:0]      led_q;
  logic            overflow_q;
  tx_state_t       state_q, state_d;
  logic [SW-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            start_q, start_d;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      pb_s1_q   <= 1'b0;
      pb_s2_q   <= 1'b0;
      pb_prev_q <= 1'b0;
    end else begin
      pb_s1_q   <= PB_state;
      pb_s2_q   <= pb_s1_q;
      pb_prev_q <= pb_s2_q;
    end
  end

  assign press      = pb_s2_q & ~pb_prev_q;
  assign key        = key_to_ascii(num);
  assign repeat_hit = REPEAT_EN && rep_active_q && pb_s2_q &&
                      (rep_cnt_q == RW'(REPEAT_CYCLES - 1));
  assign push       = (press & key.valid) | repeat_hit;
  assign push_data  = press ? key.ascii : rep_code_q;

  // Auto-repeat timer: restarts on each accepted press, cleared when the key is released.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_q    <= '0;
      rep_active_q <= 1'b0;
      rep_code_q   <= '0;
    end else if (press) begin
      rep_active_q <= key.valid & REPEAT_EN;
      rep_cnt_q    <= '0;
      rep_code_q   <= key.ascii;
    end else if (!pb_s2_q) begin
      rep_active_q <= 1'b0;
      rep_cnt_q    <= '0;
    end else if (rep_active_q) begin
      rep_cnt_q <= repeat_hit ? '0 : rep_cnt_q + 1'b1;
    end
  end

  // Unlock pulse down-counter; a new unlock press reloads it.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      unlock_cnt_q <= '0;
    end else if (press && key.valid && key.unlock) begin
      unlock_cnt_q <= UW'(UNLOCK_CYCLES);
    end else if (unlock_cnt_q != '0) begin
      unlock_cnt_q <= unlock_cnt_q - 1'b1;
    end
  end

  // LED tracks the last accepted press; overflow flags a push lost to a full queue.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      led_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (press && key.valid) led_q <= key.ascii;
      overflow_q <= push & full & ~pop;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (FPGA_CLK1_50),
    .rst_ni (reset_n),
    .push_i (push),
    .data_i (push_data),
    .pop_i  (pop),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );

  // TX FSM state register.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      data_q      <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      data_q      <= data_d;
      start_q     <= start_d;
    end
  end

  // TX FSM next state: load and pop, hold the strobe, then wait for the UART to go idle.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    data_d      = data_q;
    start_d     = start_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !TxD_busy) begin
          data_d      = head;
          pop         = 1'b1;
          start_d     = 1'b1;
          pulse_cnt_d = '0;
          state_d     = PULSE;
        end
      end
      PULSE: begin
        if (pulse_cnt_q == SW'(START_CYCLES - 1)) begin
          start_d = 1'b0;
          state_d = GAP;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (!TxD_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign TxD_data      = data_q;
  assign TxD_start     = start_q;
  assign unlock_signal = (unlock_cnt_q != '0);
  assign LED           = led_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_keypad_uart_encoder.sv
// Self-checking bench: directed scenarios plus random presses against an edge-indexed timeline model.
module tb_keypad_uart_encoder;

  localparam int DEPTH = 4;
  localparam int START = 4;
  localparam int REP   = 20;
  localparam int UNL   = 10;

  logic       FPGA_CLK1_50 = 1'b0;
  logic       reset_n      = 1'b0;
  logic [3:0] num          = 4'd0;
  logic       PB_state     = 1'b0;
  logic       TxD_busy     = 1'b0;
  logic [7:0] TxD_data, LED;
  logic       TxD_start, unlock_signal, overflow;

  int checks = 0;
  int errors = 0;

  always #10 FPGA_CLK1_50 = ~FPGA_CLK1_50;

  keypad_uart_encoder #(
    .DEPTH        (DEPTH),
    .START_CYCLES (START),
    .REPEAT_EN    (1'b1),
    .REPEAT_CYCLES(REP),
    .UNLOCK_CYCLES(UNL)
  ) dut (
    .FPGA_CLK1_50 (FPGA_CLK1_50),
    .reset_n      (reset_n),
    .num          (num),
    .PB_state     (PB_state),
    .TxD_busy     (TxD_busy),
    .TxD_data     (TxD_data),
    .TxD_start    (TxD_start),
    .unlock_signal(unlock_signal),
    .LED          (LED),
    .overflow     (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is counted in clock edges; each output is derived from the edge of the last event.
  logic [7:0] mq[$];
  int         e = 0;
  bit         h1, h2, h3;
  bit         ld_valid, gap_done, un_valid, rep_on, pop_now, psh, ok, ul;
  int         ld_edge, un_edge, rep_base;
  logic [7:0] rep_code, pc, c;
  logic [7:0] exp_data = 8'h00, exp_led = 8'h00;
  bit         exp_ovf, exp_start, exp_unl;

  function automatic void decode(input logic [3:0] k, output bit v, output bit u,
                                 output logic [7:0] a);
    v = (k < 4'd10) || (k == 4'd13) || (k == 4'd14);
    u = (k == 4'd13);
    if (k < 4'd10)       a = 8'h30 + {4'h0, k};
    else if (k == 4'd14) a = 8'h41;
    else                 a = 8'h37;
  endfunction

  initial forever begin
    @(posedge FPGA_CLK1_50 or negedge reset_n);
    if (!reset_n) begin
      mq.delete();
      {h1, h2, h3} = 3'b000;
      ld_valid = 0; gap_done = 0; un_valid = 0; rep_on = 0;
      exp_data = 8'h00; exp_led = 8'h00; exp_ovf = 0; exp_start = 0; exp_unl = 0;
    end else begin
      e++;
      // h2/h3 are the raw PB samples taken two and three edges ago.
      pop_now = (mq.size() > 0) && !TxD_busy && (!ld_valid || gap_done);
      if (ld_valid && !gap_done && e >= ld_edge + START + 1 && !TxD_busy) gap_done = 1;
      if (pop_now) begin
        exp_data = mq.pop_front();
        ld_valid = 1; ld_edge = e; gap_done = 0;
      end
      psh = 0;
      if (h2 && !h3) begin
        decode(num, ok, ul, c);
        if (ok) begin
          psh = 1; pc = c; exp_led = c;
          rep_on = 1; rep_base = e; rep_code = c;
          if (ul) begin un_valid = 1; un_edge = e; end
        end else begin
          rep_on = 0;
        end
      end else if (rep_on) begin
        if (!h2) rep_on = 0;
        else if (e - rep_base == REP) begin
          psh = 1; pc = rep_code; rep_base = e;
        end
      end
      exp_ovf = 0;
      if (psh) begin
        if (mq.size() == DEPTH) exp_ovf = 1;
        else mq.push_back(pc);
      end
      h3 = h2; h2 = h1; h1 = PB_state;
      exp_start = ld_valid && (e < ld_edge + START);
      exp_unl   = un_valid && (e < un_edge + UNL);
    end
  end

  // ---------------- compare + monitor ----------------
  logic [7:0] sent_q[$];
  bit         prev_start = 0;
  int         ovf_seen = 0;
  int         unl_hi = 0;

  initial forever begin
    @(negedge FPGA_CLK1_50);
    chk("model TxD_start", 32'(TxD_start), 32'(exp_start));
    chk("model TxD_data", 32'(TxD_data), 32'(exp_data));
    chk("model LED", 32'(LED), 32'(exp_led));
    chk("model unlock_signal", 32'(unlock_signal), 32'(exp_unl));
    chk("model overflow", 32'(overflow), 32'(exp_ovf));
    if (TxD_start && !prev_start) sent_q.push_back(TxD_data);
    prev_start = TxD_start;
    if (overflow) ovf_seen++;
    if (unlock_signal) unl_hi++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge FPGA_CLK1_50);
    #2;
  endtask

  task automatic rtick(input int n);
    repeat (n) begin
      @(posedge FPGA_CLK1_50);
      #2;
      TxD_busy = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int low);
    num = k; PB_state = 1'b1;
    tick(hold);
    PB_state = 1'b0;
    tick(low);
  endtask

  function automatic logic [7:0] sent_at(input int i);
    return (i < sent_q.size()) ? sent_q[i] : 8'hxx;
  endfunction

  int n0, hi, cnt41;

  initial begin
    tick(3);
    chk("reset TxD_start", 32'(TxD_start), 32'd0);
    chk("reset TxD_data", 32'(TxD_data), 32'd0);
    chk("reset LED", 32'(LED), 32'd0);
    chk("reset unlock", 32'(unlock_signal), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick(3);

    // 1: single press, latency and strobe width
    num = 4'd5; PB_state = 1'b1;
    tick(1); PB_state = 1'b0;
    tick(2);
    chk("t1 start before 4th edge", 32'(TxD_start), 32'd0);
    tick(1);
    chk("t1 start after 4th edge", 32'(TxD_start), 32'd1);
    chk("t1 data", 32'(TxD_data), 32'h35);
    chk("t1 LED", 32'(LED), 32'h35);
    hi = 1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (TxD_start) hi++;
    end
    chk("t1 start width", 32'(hi), 32'd4);
    tick(10);

    // 2: unlock press and retrigger
    n0 = sent_q.size();
    unl_hi = 0;
    press(4'd13, 1, 2);
    press(4'd13, 1, 30);
    chk("t2 unlock high cycles", 32'(unl_hi), 32'd13);
    chk("t2 unlock ended", 32'(unlock_signal), 32'd0);
    chk("t2 sent count", 32'(sent_q.size() - n0), 32'd2);
    chk("t2 first char", 32'(sent_at(n0)), 32'h37);
    chk("t2 second char", 32'(sent_at(n0 + 1)), 32'h37);

    // 3: ignored codes
    n0 = sent_q.size();
    press(4'd11, 2, 5);
    press(4'd12, 2, 20);
    chk("t3 no tx", 32'(sent_q.size() - n0), 32'd0);
    chk("t3 LED kept", 32'(LED), 32'h37);
    chk("t3 no overflow", 32'(ovf_seen), 32'd0);

    // 4: overflow with busy held, then drain in order
    TxD_busy = 1'b1;
    for (int i = 1; i <= 5; i++) press(4'(i), 2, 3);
    chk("t4 overflow pulses", 32'(ovf_seen), 32'd1);
    n0 = sent_q.size();
    TxD_busy = 1'b0;
    tick(40);
    chk("t4 drained count", 32'(sent_q.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) chk("t4 order", 32'(sent_at(n0 + i)), 32'h31 + 32'(i));

    // 5: auto-repeat on a held key
    n0 = sent_q.size();
    press(4'd14, 65, 40);
    cnt41 = 0;
    for (int i = n0; i < sent_q.size(); i++) if (sent_q[i] == 8'h41) cnt41++;
    chk("t5 repeat count", 32'(cnt41), 32'd4);
    chk("t5 total sent", 32'(sent_q.size() - n0), 32'd4);
    chk("t5 LED", 32'(LED), 32'h41);

    // 6: reset during a pulse with entries queued
    TxD_busy = 1'b1;
    press(4'd7, 2, 3);
    press(4'd8, 2, 3);
    press(4'd9, 2, 3);
    TxD_busy = 1'b0;
    tick(2);
    chk("t6 in pulse", 32'(TxD_start), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6 start cleared", 32'(TxD_start), 32'd0);
    chk("t6 LED cleared", 32'(LED), 32'd0);
    tick(3);
    reset_n = 1'b1;
    n0 = sent_q.size();
    tick(30);
    chk("t6 no tx after reset", 32'(sent_q.size() - n0), 32'd0);
    chk("t6 LED still 0", 32'(LED), 32'd0);

    // random presses with random busy, checked every cycle by the model
    for (int i = 0; i < 40; i++) begin
      num = 4'($urandom_range(0, 15));
      PB_state = 1'b1;
      rtick($urandom_range(1, 45));
      PB_state = 1'b0;
      rtick($urandom_range(1, 10));
    end
    TxD_busy = 1'b0;
    tick(80);
    chk("random drained", 32'(exp_start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
